// File: rtl/split_mem_responder.sv
// Memory-side responder for the LC-3b fetch and data ports: arbitrates both onto one
// physical line interface and serves repeated fetches from a coherent one-line buffer.
module split_mem_responder #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned SEL_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ifetch_read,
  input  logic [ADDR_W-1:0] ifetch_address,
  output logic [LINE_W-1:0] ifetch_rdata,
  output logic              ifetch_resp,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] mem_wdata,
  input  logic [SEL_W-1:0]  mem_sel,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  output logic [SEL_W-1:0]  pmem_sel,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_ACC  = 2'd1,
    I_FILL = 2'd2
  } state_t;

  state_t              state;
  logic                buf_valid;
  logic [ADDR_W-1:0]   buf_tag;
  logic [LINE_W-1:0]   buf_data;
  logic                last_grant_data;
  logic                op_write;

  logic                hit_c;
  logic                data_req_c;
  logic                fetch_miss_c;
  logic                grant_data_c;
  logic                grant_fetch_c;
  logic                fill_done_c;

  // Buffer hit and IDLE arbitration; a write to the buffered line blocks the hit
  always_comb begin
    hit_c         = 1'b0;
    data_req_c    = 1'b0;
    fetch_miss_c  = 1'b0;
    grant_data_c  = 1'b0;
    grant_fetch_c = 1'b0;
    if (state == IDLE) begin
      hit_c         = ifetch_read & buf_valid & (ifetch_address == buf_tag)
                      & ~(mem_write & (mem_address == buf_tag));
      data_req_c    = mem_read | mem_write;
      fetch_miss_c  = ifetch_read & ~hit_c;
      grant_data_c  = data_req_c & (~fetch_miss_c | ~last_grant_data);
      grant_fetch_c = fetch_miss_c & (~data_req_c | last_grant_data);
    end
  end

  // Response paths are zero-wait: hits and pmem completions respond in the same cycle
  always_comb begin
    fill_done_c  = (state == I_FILL) & pmem_resp;
    ifetch_resp  = hit_c | fill_done_c;
    ifetch_rdata = '0;
    if (hit_c) begin
      ifetch_rdata = buf_data;
    end else if (fill_done_c) begin
      ifetch_rdata = pmem_rdata;
    end
    mem_resp  = (state == D_ACC) & pmem_resp;
    mem_rdata = '0;
    if (mem_resp && !op_write) begin
      mem_rdata = pmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      buf_valid       <= 1'b0;
      buf_tag         <= '0;
      buf_data        <= '0;
      last_grant_data <= 1'b0;
      op_write        <= 1'b0;
      pmem_read       <= 1'b0;
      pmem_write      <= 1'b0;
      pmem_address    <= '0;
      pmem_wdata      <= '0;
      pmem_sel        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data_c) begin
            state           <= D_ACC;
            last_grant_data <= 1'b1;
            op_write        <= mem_write;
            pmem_address    <= mem_address;
            pmem_wdata      <= mem_wdata;
            pmem_sel        <= mem_write ? mem_sel : '1;
            pmem_write      <= mem_write;
            pmem_read       <= ~mem_write;
          end else if (grant_fetch_c) begin
            state           <= I_FILL;
            last_grant_data <= 1'b0;
            op_write        <= 1'b0;
            pmem_address    <= ifetch_address;
            pmem_wdata      <= '0;
            pmem_sel        <= '1;
            pmem_write      <= 1'b0;
            pmem_read       <= 1'b1;
          end
        end
        D_ACC: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            // Keep the instruction buffer coherent with data-port writes
            if (op_write && buf_valid && (pmem_address == buf_tag)) begin
              for (int unsigned i = 0; i < SEL_W; i++) begin
                if (pmem_sel[i]) begin
                  buf_data[8*i +: 8] <= pmem_wdata[8*i +: 8];
                end
              end
            end
          end
        end
        I_FILL: begin
          if (pmem_resp) begin
            state     <= IDLE;
            pmem_read <= 1'b0;
            buf_valid <= 1'b1;
            buf_tag   <= pmem_address;
            buf_data  <= pmem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/split_mem_responder.md
Name: split_mem_responder

Overview:
- Memory-side responder for the pipelined LC-3b core's two line-granular request ports: instruction fetch (read-only) and data (read/write with byte select).
- Arbitrates both ports onto a single physical-memory line interface.
- Holds a one-line instruction buffer so repeated fetches from the same line respond without a memory access.
- The buffer is kept coherent with data-port writes by byte-merging.

Parameters:
ADDR_W, 12, line address width (byte address bits [15:4])
LINE_W, 128, line data width in bits
SEL_W, 16, byte-select width, equal to LINE_W/8

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset_n  input  1  asynchronous active-low reset
ifetch_read  input  1  fetch request; may be held high continuously
ifetch_address  input  ADDR_W  fetch line address
ifetch_rdata  output  LINE_W  fetch line data; valid only while ifetch_resp=1
ifetch_resp  output  1  one-cycle fetch completion pulse
mem_read  input  1  data read request
mem_write  input  1  data write request
mem_address  input  ADDR_W  data line address
mem_wdata  input  LINE_W  data write line
mem_sel  input  SEL_W  write byte enables; bit i covers bits [8i+7:8i]
mem_rdata  output  LINE_W  data read line; valid only while mem_resp=1
mem_resp  output  1  one-cycle data completion pulse
pmem_read  output  1  physical read strobe
pmem_write  output  1  physical write strobe
pmem_address  output  ADDR_W  physical line address
pmem_wdata  output  LINE_W  physical write data
pmem_sel  output  SEL_W  physical byte enables; all ones on reads
pmem_rdata  input  LINE_W  physical read data
pmem_resp  input  1  physical completion pulse

Behaviour:
- FSM states: IDLE, D_ACC, I_FILL.
- Reset (async, reset_n=0):
  - state=IDLE, buffer valid=0, last_grant=IFETCH.
  - All outputs 0 (pmem_read, pmem_write, resp pulses, rdata outputs, pmem_address/wdata/sel).
  - Reset asserted mid-transaction abandons the transaction; no response is issued.
- Buffer hit (evaluated in IDLE only):
  - hit = ifetch_read & valid & (ifetch_address==buf_tag) & ~(mem_write & mem_address==buf_tag).
  - On a hit: ifetch_resp=1 and ifetch_rdata=buf_data in the same cycle (zero-wait). FSM stays in IDLE.
  - A hit is served in parallel with a data grant made in the same cycle.
- IDLE grant (data request = mem_read | mem_write; fetch miss = ifetch_read & ~hit):
  - Data request only → D_ACC.
  - Fetch miss only → I_FILL.
  - Both present: last_grant=DATA → I_FILL, otherwise → D_ACC. last_grant is updated on every grant.
  - At grant, latch into pmem_address/wdata/sel: address, wdata, sel, and op. mem_write=mem_read=1 is treated as a write.
  - Strobes assert from the cycle after the grant.
- D_ACC:
  - Hold pmem_read or pmem_write, with latched address/data/sel, until pmem_resp.
  - pmem_sel=all ones on reads.
  - On pmem_resp: mem_resp=1 for that cycle, mem_rdata=pmem_rdata (reads; 0 on writes), strobes drop the same cycle, next state IDLE.
  - Write with latched address==buf_tag and valid: merge each byte with sel=1 into buf_data on the pmem_resp edge.
- I_FILL:
  - Hold pmem_read on the latched fetch address until pmem_resp.
  - On pmem_resp: ifetch_resp=1, ifetch_rdata=pmem_rdata; load buf_tag and buf_data; valid=1; next state IDLE.
- General rules:
  - Requests are sampled only at grant. A request dropped or changed mid-transaction does not abort it, and its response pulse is still issued.
  - A request still high in the cycle after its response is a new request.
  - Minimum latency:
    - hit: 0 cycles
    - miss/data: grant cycle + 1 strobe cycle + memory latency
  - pmem_resp outside D_ACC/I_FILL is ignored.

Test Plan:
- Reset, then ifetch_read=1 addr 0x010, pmem replies after 2 cycles with line A → pmem_read high 2 cycles, ifetch_resp pulses with A; next cycle same addr → ifetch_resp=1 same cycle, pmem_read stays 0.
- mem_read addr 0x020 and ifetch miss addr 0x030 both in IDLE after reset (last_grant=IFETCH) → data served first; next grant goes to I_FILL at 0x030 even though a new data request is pending.
- Buffer holds line 0x010 = all 0x11; mem_write addr 0x010, wdata all 0xFF, sel=16'h0003 → after mem_resp, fetch of 0x010 hits with bytes 0–1 = 0xFF, rest 0x11. During the write grant cycle, the fetch of 0x010 does not hit.
- mem_read and mem_write both 1, addr 0x040 → pmem_write=1, pmem_read=0, pmem_sel=mem_sel.
- reset_n pulsed low while in I_FILL → all outputs 0 immediately; no ifetch_resp; next fetch of the previously buffered line misses.
- mem_read dropped one cycle after grant → transaction completes; mem_resp pulses once; FSM returns to IDLE.
